// File: rtl/pkt_rr_fifo_arbiter_pkg.sv
// Shared types and constants for the packet round-robin FIFO arbiter.
//   state_t            : arbiter FSM states
//   LEN_W              : width of the header word-count field
//   LEN_LSB_DEFAULT    : default bit position of the word-count field
//   idx_width()        : queue index width for a given queue count
package pkt_rr_fifo_arbiter_pkg;

    localparam int unsigned LEN_W           = 16;
    localparam int unsigned LEN_LSB_DEFAULT = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_t;

    // Index width for n queues; a single queue still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pkt_rr_fifo_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per queue
//   last  : index of the most recently completed grant
//   grant : first requesting index after last, wrapping
//   valid : at least one request is present
module pkt_rr_fifo_arbiter_rr_pick
    import pkt_rr_fifo_arbiter_pkg::*;
#(
    parameter int unsigned NUM_QUEUES = 4,
    parameter int unsigned QW         = idx_width(NUM_QUEUES)
) (
    input  logic [NUM_QUEUES-1:0] req,
    input  logic [QW-1:0]         last,
    output logic [QW-1:0]         grant,
    output logic                  valid
);

    logic [QW-1:0] idx;

    // Scan last+1 .. last+NUM_QUEUES; truncation to QW bits wraps (power-of-2 count).
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NUM_QUEUES; i++) begin
            idx = QW'(32'(last) + i);
            if (!valid && req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_rr_fifo_arbiter.sv
// Packet-granular round-robin arbiter draining NUM_QUEUES non-fallthrough FIFOs.
//   clk, reset         : clock, synchronous active-high reset
//   in_data/in_ctrl    : FIFO dout buses, queue i at slice i
//   in_empty           : FIFO empty flags
//   in_rd_en           : FIFO read enables (one-hot or zero)
//   out_data/out_ctrl  : forwarded word, valid when out_wr
//   out_wr             : registered copy of |in_rd_en
//   out_rdy            : downstream has room for at least two more words
//   cur_queue          : queue currently granted
module pkt_rr_fifo_arbiter
    import pkt_rr_fifo_arbiter_pkg::*;
#(
    parameter int unsigned NUM_QUEUES = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = 8,
    parameter int unsigned LEN_LSB    = LEN_LSB_DEFAULT
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
    input  logic [NUM_QUEUES-1:0]            in_empty,
    output logic [NUM_QUEUES-1:0]            in_rd_en,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    output logic [idx_width(NUM_QUEUES)-1:0] cur_queue
);

    localparam int unsigned QW = idx_width(NUM_QUEUES);

    logic [DATA_WIDTH-1:0] q_data [NUM_QUEUES];
    logic [CTRL_WIDTH-1:0] q_ctrl [NUM_QUEUES];

    state_t          state;
    logic [LEN_W-1:0] cnt;
    logic [QW-1:0]   grant;
    logic [QW-1:0]   rr_ptr;
    logic [QW-1:0]   sel_d;

    logic [QW-1:0]    pick_idx;
    logic             pick_valid;
    logic             rd_ok;
    logic             rd_fire;
    logic [QW-1:0]    rd_sel;
    logic [LEN_W-1:0] len_raw;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] hdr_cnt;

    // Unpack the flat FIFO buses.
    for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_unpack
        assign q_data[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign q_ctrl[i] = in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
    end

    pkt_rr_fifo_arbiter_rr_pick #(
        .NUM_QUEUES (NUM_QUEUES),
        .QW         (QW)
    ) u_rr_pick (
        .req   (~in_empty),
        .last  (rr_ptr),
        .grant (pick_idx),
        .valid (pick_valid)
    );

    // Read decision; the header length is read straight off the granted FIFO dout in HDR.
    always_comb begin
        rd_ok    = out_rdy && !in_empty[grant];
        len_raw  = q_data[grant][LEN_LSB +: LEN_W];
        len_eff  = (len_raw < LEN_W'(2)) ? LEN_W'(2) : len_raw;
        hdr_cnt  = len_eff - LEN_W'(1) - LEN_W'(rd_ok);
        rd_fire  = 1'b0;
        rd_sel   = grant;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (out_rdy && pick_valid) begin
                        rd_fire = 1'b1;
                        rd_sel  = pick_idx;
                    end
                end
                HDR, BODY: rd_fire = rd_ok;
                default:   rd_fire = 1'b0;
            endcase
        end
        in_rd_en = rd_fire ? (NUM_QUEUES'(1) << rd_sel) : '0;
    end

    // Arbiter FSM; the grant is held until the packet's last read is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            grant  <= '0;
            rr_ptr <= QW'(NUM_QUEUES - 1);
            sel_d  <= '0;
            out_wr <= 1'b0;
        end else begin
            out_wr <= rd_fire;
            if (rd_fire) begin
                sel_d <= rd_sel;
            end
            case (state)
                IDLE: begin
                    if (rd_fire) begin
                        grant <= rd_sel;
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (hdr_cnt == '0) begin
                        cnt    <= '0;
                        rr_ptr <= grant;
                        state  <= IDLE;
                    end else begin
                        cnt   <= hdr_cnt;
                        state <= BODY;
                    end
                end
                BODY: begin
                    if (rd_fire) begin
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            rr_ptr <= grant;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output mux follows the registered read select so back-to-back packets stay intact.
    assign out_data  = out_wr ? q_data[sel_d] : '0;
    assign out_ctrl  = out_wr ? q_ctrl[sel_d] : '0;
    assign cur_queue = grant;

endmodule

// File: tb/tb_pkt_rr_fifo_arbiter.sv
// Scoreboard bench for pkt_rr_fifo_arbiter with behavioural non-fallthrough FIFOs.
module tb_pkt_rr_fifo_arbiter;

    localparam int NQ = 4;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int QW = 2;

    typedef logic [CW+DW-1:0] word_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [NQ*DW-1:0] in_data;
    logic [NQ*CW-1:0] in_ctrl;
    logic [NQ-1:0]   in_empty;
    logic [NQ-1:0]   in_rd_en;
    logic [DW-1:0]   out_data;
    logic [CW-1:0]   out_ctrl;
    logic            out_wr;
    logic            out_rdy;
    logic [QW-1:0]   cur_queue;

    word_t       fifo_q [NQ][$];
    word_t       exp_q [$];
    int          rd_log [$];
    int          cyc;
    int          wr_cnt;
    int          checks;
    int          errors;
    string       chk_name [$];
    logic [63:0] chk_act [$];
    logic [63:0] chk_exp [$];

    always #5 clk = ~clk;

    pkt_rr_fifo_arbiter #(
        .NUM_QUEUES (NQ),
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CW),
        .LEN_LSB    (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_wr    (out_wr),
        .out_rdy   (out_rdy),
        .cur_queue (cur_queue)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO models: dout updates the cycle after rd_en; reset empties them.
    always @(posedge clk) begin
        word_t w;
        for (int i = 0; i < NQ; i++) begin
            if (reset) begin
                fifo_q[i].delete();
                in_data[i*DW +: DW] <= '0;
                in_ctrl[i*CW +: CW] <= '0;
                in_empty[i]         <= 1'b1;
            end else begin
                if (in_rd_en[i] && fifo_q[i].size() > 0) begin
                    w = fifo_q[i].pop_front();
                    in_data[i*DW +: DW] <= w[DW-1:0];
                    in_ctrl[i*CW +: CW] <= w[DW+CW-1:DW];
                    rd_log.push_back(cyc * NQ + i);
                end
                in_empty[i] <= (fifo_q[i].size() == 0);
            end
        end
    end

    // Monitor: scoreboard pops, protocol invariants, and queued point checks.
    always @(negedge clk) begin
        string       n;
        logic [63:0] a;
        logic [63:0] e;
        word_t       ew;
        while (chk_name.size() > 0) begin
            n = chk_name.pop_front();
            a = chk_act.pop_front();
            e = chk_exp.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", n, a, e);
            end
        end
        if (reset === 1'b0) begin
            checks++;
            if (!$onehot0(in_rd_en)) begin
                errors++;
                $display("FAIL rd_en_onehot: got %b expected at most one bit", in_rd_en);
            end
            checks++;
            if ((in_rd_en & in_empty) != '0) begin
                errors++;
                $display("FAIL rd_on_empty: rd_en %b empty %b expected no overlap", in_rd_en, in_empty);
            end
            checks++;
            if (!out_rdy && in_rd_en != '0) begin
                errors++;
                $display("FAIL rd_without_rdy: got rd_en %b expected 0", in_rd_en);
            end
            if (out_wr) begin
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected no output", {out_ctrl, out_data});
                end else begin
                    ew = exp_q.pop_front();
                    if ({out_ctrl, out_data} !== ew) begin
                        errors++;
                        $display("FAIL out_word: got %0h expected %0h", {out_ctrl, out_data}, ew);
                    end
                end
            end
        end
    end

    function automatic word_t mk_word(input int q, input int pid, input int widx, input int len);
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        d = {8'(q), 8'(pid), 16'(widx), 16'hCAFE, (widx == 0) ? 16'(len) : 16'(16'h5A00 + widx)};
        c = (widx == 0) ? 8'hFF : 8'(widx);
        return {c, d};
    endfunction

    task automatic expect_val(input string n, input logic [63:0] act, input logic [63:0] exp);
        chk_name.push_back(n);
        chk_act.push_back(act);
        chk_exp.push_back(exp);
    endtask

    task automatic load_pkt(input int q, input int pid, input int len, input int first, input int last);
        for (int k = first; k < last; k++) fifo_q[q].push_back(mk_word(q, pid, k, len));
    endtask

    task automatic expect_pkt(input int q, input int pid, input int len, input int nwords);
        for (int k = 0; k < nwords; k++) exp_q.push_back(mk_word(q, pid, k, len));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        out_rdy = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_drain(input string n, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        expect_val({n, "_left_in_scoreboard"}, 64'(exp_q.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_reads(input string n, input int target, input int budget);
        int k = 0;
        while (rd_log.size() < target && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        expect_val({n, "_read_wait"}, 64'(rd_log.size() >= target), 64'd1);
    endtask

    function automatic int count_q(input int from, input int q);
        int c = 0;
        for (int k = from; k < rd_log.size(); k++) if (rd_log[k] % NQ == q) c++;
        return c;
    endfunction

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base_rd;
        int base_wr;
        int span;
        reset   = 1'b1;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        expect_val("rst_rd_en", 64'(in_rd_en), 64'd0);
        expect_val("rst_out_wr", 64'(out_wr), 64'd0);
        expect_val("rst_out_data", out_data, 64'd0);
        expect_val("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        expect_val("rst_cur_queue", 64'(cur_queue), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single L=4 packet on q0.
        base_rd = rd_log.size();
        base_wr = wr_cnt;
        load_pkt(0, 1, 4, 0, 4);
        expect_pkt(0, 1, 4, 4);
        wait_drain("t1", 60);
        expect_val("t1_reads", 64'(rd_log.size() - base_rd), 64'd4);
        expect_val("t1_reads_q0", 64'(count_q(base_rd, 0)), 64'd4);
        span = (rd_log.size() >= base_rd + 4) ? (rd_log[base_rd+3] / NQ - rd_log[base_rd] / NQ) : -1;
        expect_val("t1_read_span", 64'(span), 64'd3);
        expect_val("t1_writes", 64'(wr_cnt - base_wr), 64'd4);

        // Round robin over q0..q2, two L=3 packets each.
        do_reset();
        base_wr = wr_cnt;
        for (int q = 0; q < 3; q++) begin
            load_pkt(q, 10 + q, 3, 0, 3);
            load_pkt(q, 20 + q, 3, 0, 3);
        end
        for (int q = 0; q < 3; q++) expect_pkt(q, 10 + q, 3, 3);
        for (int q = 0; q < 3; q++) expect_pkt(q, 20 + q, 3, 3);
        wait_drain("t2", 120);
        expect_val("t2_writes", 64'(wr_cnt - base_wr), 64'd18);

        // Minimal length: L=2 then L=0 on q3.
        do_reset();
        base_rd = rd_log.size();
        base_wr = wr_cnt;
        load_pkt(3, 31, 2, 0, 2);
        load_pkt(3, 32, 0, 0, 2);
        expect_pkt(3, 31, 2, 2);
        expect_pkt(3, 32, 0, 2);
        wait_drain("t3", 60);
        expect_val("t3_reads", 64'(count_q(base_rd, 3)), 64'd4);
        expect_val("t3_writes", 64'(wr_cnt - base_wr), 64'd4);
        expect_val("t3_cur_queue", 64'(cur_queue), 64'd3);

        // Back-pressure: out_rdy low for 3 cycles after word 2 of an L=6 packet.
        do_reset();
        base_rd = rd_log.size();
        base_wr = wr_cnt;
        load_pkt(0, 40, 6, 0, 6);
        expect_pkt(0, 40, 6, 6);
        begin
            int k = 0;
            while (wr_cnt < base_wr + 2 && k < 50) begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        out_rdy = 1'b0;
        span = rd_log.size();
        repeat (3) @(posedge clk);
        #1;
        expect_val("t4_reads_while_low", 64'(rd_log.size() - span), 64'd0);
        expect_val("t4_grant_held", 64'(cur_queue), 64'd0);
        out_rdy = 1'b1;
        wait_drain("t4", 60);
        expect_val("t4_reads", 64'(rd_log.size() - base_rd), 64'd6);
        expect_val("t4_writes", 64'(wr_cnt - base_wr), 64'd6);

        // Starved mid-packet: q1 runs dry after word 3 of L=5 while q2 waits.
        do_reset();
        base_rd = rd_log.size();
        load_pkt(1, 50, 5, 0, 3);
        load_pkt(2, 51, 2, 0, 2);
        expect_pkt(1, 50, 5, 5);
        expect_pkt(2, 51, 2, 2);
        wait_reads("t5", base_rd + 3, 40);
        repeat (5) begin
            @(posedge clk);
            #1;
            expect_val("t5_grant_held", 64'(cur_queue), 64'd1);
        end
        expect_val("t5_q2_not_read", 64'(count_q(base_rd, 2)), 64'd0);
        load_pkt(1, 50, 5, 3, 5);
        wait_drain("t5", 60);
        expect_val("t5_reads", 64'(rd_log.size() - base_rd), 64'd7);

        // Reset in BODY, then check queue 0 wins over queue 1.
        do_reset();
        base_rd = rd_log.size();
        load_pkt(0, 60, 8, 0, 8);
        expect_pkt(0, 60, 8, 8);
        wait_reads("t6", base_rd + 3, 40);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        expect_val("t6_rd_en", 64'(in_rd_en), 64'd0);
        expect_val("t6_out_wr", 64'(out_wr), 64'd0);
        expect_val("t6_cur_queue", 64'(cur_queue), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        load_pkt(1, 61, 2, 0, 2);
        load_pkt(0, 62, 3, 0, 3);
        expect_pkt(0, 62, 3, 3);
        expect_pkt(1, 61, 2, 2);
        wait_drain("t6", 60);

        @(negedge clk);
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_rr_fifo_arbiter.md
Name: pkt_rr_fifo_arbiter

Overview:
- Packet-granular round-robin arbiter. It drains NUM_QUEUES non-fallthrough small FIFOs (data valid the cycle after rd_en) into one output stream.
- It sits between the per-port input FIFOs and the downstream pipeline stage.
- It issues FIFO reads at up to one word per cycle. It never interleaves packets.
- Packet length comes from the header word, so no read ever crosses a packet boundary.

Parameters:
- NUM_QUEUES, 4, number of input FIFOs (power of 2, ≥2)
- DATA_WIDTH, 64, data word width
- CTRL_WIDTH, 8, ctrl word width
- LEN_LSB, 0, LSB of the 16-bit word-count field in the header word

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data  in  NUM_QUEUES*DATA_WIDTH  FIFO dout buses, queue i at slice i
- in_ctrl  in  NUM_QUEUES*CTRL_WIDTH  FIFO ctrl buses
- in_empty  in  NUM_QUEUES  FIFO empty flags
- in_rd_en  out  NUM_QUEUES  FIFO read enables, at most one bit high (one-hot or zero)
- out_data  out  DATA_WIDTH  forwarded word
- out_ctrl  out  CTRL_WIDTH  forwarded ctrl
- out_wr  out  1  out_data/out_ctrl valid this cycle
- out_rdy  in  1  downstream can take ≥2 more words (nearly-full based)
- cur_queue  out  log2(NUM_QUEUES)  queue currently granted (debug)

Behaviour:
- Clocking and reset: single clock domain, one clock (clk). Reset is synchronous, active-high (reset).
- Reset values:
  - in_rd_en=0, out_wr=0, out_data=0, out_ctrl=0, cur_queue=0
  - state=IDLE, word counter=0
  - rr pointer=NUM_QUEUES-1, so queue 0 wins first.
- Reset mid-packet: the packet is abandoned. The remaining words stay in the FIFO; system reset clears the FIFOs too.
- Packet format:
  - First word is the header. Its data[LEN_LSB+15:LEN_LSB] = L = total words including the header.
  - L<2 is treated as 2.
- Read-enable rule: in_rd_en[g] = state permits read & !in_empty[g] & out_rdy. No read is ever issued to an empty FIFO.
- Output timing:
  - out_wr is in_rd_en registered (|in_rd_en delayed 1 cycle).
  - out_data/out_ctrl are driven from the queue selected by the registered read select (sel_d): combinational mux of the FIFO dout.
  - Latency from rd_en to out_wr is exactly 1 cycle.
- State IDLE:
  - If out_rdy and any !in_empty, grant g = first non-empty queue after the rr pointer (wrapping).
  - Assert in_rd_en[g] (header read), latch g, go HDR.
  - Otherwise stay in IDLE.
- State HDR:
  - The header is valid on in_data[g] this cycle and out_wr=1.
  - A second read is issued if allowed (speculative; L≥2 guarantees that word exists).
  - Load counter = L-1-rd (rd = read issued this cycle).
  - If the counter would be 0, go IDLE and advance the rr pointer to g. Else go BODY.
- State BODY:
  - Issue a read whenever allowed; each issued read decrements the counter.
  - On issuing the read that takes the counter to 0, go IDLE and set rr pointer=g.
- Back-to-back packets: IDLE may issue a new header read in the cycle the previous last word appears on out_wr. The sel_d mux keeps both words correct.
- Stalls: FIFO empty mid-packet or out_rdy low just pauses reads. State and counter hold, and the grant is never released mid-packet.
- Fairness: rr pointer updates only at packet completion. A queue that stays non-empty gets at most one packet before every other non-empty queue is offered.
- Counter: 16 bits, no wrap; it never decrements below 0.

Decomposition:
- Shared package holds:
  - state enum (IDLE, HDR, BODY)
  - header length field width (16) and the LEN_LSB default
  - clog2-derived queue index width
- One sub-module is natural: rr_pick. It is combinational, taking a request vector and the last-grant pointer and producing the next grant index and valid.

Test Plan:
- Single packet: q0 holds L=4 (hdr + 3 words), out_rdy=1. Expect reads on 4 consecutive cycles, out_wr on the next 4 cycles, words in order, return to IDLE.
- Round robin: q0,q1,q2 each hold two L=3 packets. Expect output packet order q0,q1,q2,q0,q1,q2 with no interleaving.
- Minimal length: q3 holds L=2 then L=0 (treated as 2). Expect exactly 2 reads per packet and 4 out_wr total.
- Back-pressure: L=6 packet, drop out_rdy for 3 cycles after word 2. Expect no rd_en while low, no lost or duplicated word, 6 out_wr total.
- Starved mid-packet: q1 empty after word 3 of an L=5 packet for 5 cycles while q2 has data. Expect the grant held on q1, q2 not read until q1's packet completes.
- Reset mid-packet: assert reset in BODY. Next cycle in_rd_en=0, out_wr=0, state IDLE, rr pointer such that queue 0 wins next.
